// File: rtl/float16_pkg.sv
// rtl/float16_pkg.sv - shared float16 field widths, unpacked word type and converter states
package float16_pkg;

    localparam int EXP_W    = 5;
    localparam int MANT_W   = 10;
    localparam int FRAC_BW  = MANT_W + 1;
    localparam int EXP_BIAS = 15;
    localparam int SHIFT_W  = 16;

    typedef struct packed {
        logic               sign;
        logic [EXP_W-1:0]   exp;
        logic [FRAC_BW-1:0] frac;
    } float16_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        OUT
    } state_e;

endpackage

// File: rtl/float16_unpack.sv
// rtl/float16_unpack.sv - splits a float16 word into fields, zero flag and signed fixed-point shift
module float16_unpack
    import float16_pkg::*;
#(
    parameter int FRAC_W = 8
) (
    input  logic [15:0]               data_i,
    output float16_t                  fields_o,
    output logic                      zero_o,
    output logic signed [SHIFT_W-1:0] shift_o
);

    logic signed [SHIFT_W-1:0] exp_s;

    assign fields_o.sign = data_i[15];
    assign fields_o.exp  = data_i[14:10];
    // No denormals: the hidden one is present for every exponent value.
    assign fields_o.frac = {1'b1, data_i[9:0]};
    assign zero_o        = (data_i[14:0] == 15'd0);

    assign exp_s   = SHIFT_W'(data_i[14:10]);
    assign shift_o = exp_s - SHIFT_W'(EXP_BIAS + MANT_W - FRAC_W);

endmodule

// File: rtl/float_to_fixed.sv
// rtl/float_to_fixed.sv - float16 to signed Q(INT_W.FRAC_W) with a one-bit-per-cycle shifter
module float_to_fixed
    import float16_pkg::*;
#(
    parameter int INT_W  = 8,
    parameter int FRAC_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INT_W+FRAC_W-1:0]  out_data,
    output logic                     out_ovf
);

    localparam int W       = INT_W + FRAC_W;
    localparam int CNT_MAX = (11 > W - 11) ? 11 : W - 11;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    // s >= W-11 expressed on the raw exponent.
    localparam int OVF_EXP = EXP_BIAS + MANT_W - FRAC_W + W - 11;
    localparam logic signed [SHIFT_W-1:0] UNF_S = SHIFT_W'(-11);

    float16_t                  fields;
    logic                      zero;
    logic signed [SHIFT_W-1:0] shift;
    logic [SHIFT_W-1:0]        shift_abs;
    logic                      is_ovf;
    logic                      is_unf;
    logic [W-1:0]              frac_ext;
    logic [W-1:0]              mag_shift;

    state_e         state_q, state_d;
    logic [W-1:0]   mag_q, mag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           left_q, left_d;
    logic           sign_q, sign_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic           out_ovf_q, out_ovf_d;

    float16_unpack #(.FRAC_W(FRAC_W)) u_unpack (
        .data_i   (in_data),
        .fields_o (fields),
        .zero_o   (zero),
        .shift_o  (shift)
    );

    assign shift_abs = shift[SHIFT_W-1] ? -shift : shift;
    assign is_ovf    = (int'(fields.exp) >= OVF_EXP);
    assign is_unf    = (shift <= UNF_S);
    assign frac_ext  = W'(fields.frac);
    assign mag_shift = left_q ? (mag_q << 1) : (mag_q >> 1);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        cnt_d      = cnt_q;
        left_d     = left_q;
        sign_d     = sign_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (zero || is_unf) begin
                        out_data_d = '0;
                        out_ovf_d  = 1'b0;
                        state_d    = OUT;
                    end else if (is_ovf) begin
                        out_data_d = fields.sign ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                        out_ovf_d  = 1'b1;
                        state_d    = OUT;
                    end else if (shift == '0) begin
                        out_data_d = fields.sign ? -frac_ext : frac_ext;
                        out_ovf_d  = 1'b0;
                        state_d    = OUT;
                    end else begin
                        mag_d   = frac_ext;
                        cnt_d   = shift_abs[CNT_W-1:0];
                        left_d  = ~shift[SHIFT_W-1];
                        sign_d  = fields.sign;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                mag_d = mag_shift;
                cnt_d = cnt_q - CNT_W'(1);
                // The final shift and the sign application share one edge.
                if (cnt_q <= CNT_W'(1)) begin
                    out_data_d = sign_q ? -mag_shift : mag_shift;
                    out_ovf_d  = 1'b0;
                    state_d    = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mag_q      <= '0;
            cnt_q      <= '0;
            left_q     <= 1'b0;
            sign_q     <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            cnt_q      <= cnt_d;
            left_q     <= left_d;
            sign_q     <= sign_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_float_to_fixed.sv
// tb/tb_float_to_fixed.sv - directed table-driven bench for float_to_fixed
module tb_float_to_fixed;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;

    int total;
    int bad;

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    float_to_fixed #(.INT_W(8), .FRAC_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Presents one word, measures latency in edges (accept edge counts as 1).
    task automatic send(input logic [15:0] d, output int lat);
        @(negedge clk);
        check($sformatf("ready_before_%04h", d), 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check($sformatf("busy_after_accept_%04h", d), 32'(in_ready), 32'd0);
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        send(v.din, lat);
        check($sformatf("data_%04h", v.din), 32'(out_data), 32'(v.dout));
        check($sformatf("ovf_%04h", v.din), 32'(out_ovf), 32'(v.ovf));
        check($sformatf("lat_%04h", v.din), 32'(lat), 32'(v.lat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        total = 0;
        bad   = 0;
        vecs[0]  = '{16'h3C00, 16'h0100, 1'b0, 3};
        vecs[1]  = '{16'hC100, 16'hFD80, 1'b0, 2};
        vecs[2]  = '{16'h5640, 16'h6400, 1'b0, 5};
        vecs[3]  = '{16'h5A40, 16'h7FFF, 1'b1, 1};
        vecs[4]  = '{16'hDA40, 16'h8000, 1'b1, 1};
        vecs[5]  = '{16'h1400, 16'h0000, 1'b0, 1};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 1};
        vecs[7]  = '{16'h8000, 16'h0000, 1'b0, 1};
        vecs[8]  = '{16'h4400, 16'h0400, 1'b0, 1};
        vecs[9]  = '{16'hC400, 16'hFC00, 1'b0, 1};
        vecs[10] = '{16'h1FFF, 16'h0001, 1'b0, 11};
        vecs[11] = '{16'h1BFF, 16'h0000, 1'b0, 1};
        vecs[12] = '{16'h57FF, 16'h7FF0, 1'b0, 5};
        vecs[13] = '{16'hD7FF, 16'h8010, 1'b0, 5};
        vecs[14] = '{16'h7C00, 16'h7FFF, 1'b1, 1};
        vecs[15] = '{16'h0001, 16'h0000, 1'b0, 1};
        vecs[16] = '{16'h4E00, 16'h1800, 1'b0, 3};
        vecs[17] = '{16'hBD55, 16'hFEAB, 1'b0, 3};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_out_ovf", 32'(out_ovf), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure on the 100.0 result.
        out_ready = 1'b0;
        send(16'h5640, lat);
        check("bp_lat", 32'(lat), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_data", 32'(out_data), 32'h6400);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_in_ready_after", 32'(in_ready), 32'd1);
        check("bp_valid_after", 32'(out_valid), 32'd0);

        // Reset in the middle of SHIFT drops the word.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h5640;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_shift_valid", 32'(out_valid), 32'd0);
        check("rst_shift_data", 32'(out_data), 32'd0);
        check("rst_shift_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        run_vec(vecs[0]);

        // Reset in OUT with out_ready high still clears the result.
        send(16'h5A40, lat);
        check("rst_out_pre_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_vec(vecs[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
